// File: rtl/vproc_red_lanes.sv
// Multi-lane vector reduction unit: LANES elements per beat are folded through a
// combinational lane tree into a scalar accumulator, yielding one result per instruction.
module vproc_red_lanes #(
    parameter int unsigned LANES = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  async_rst_ni,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  in_first_i,
    input  logic                  in_last_i,
    input  logic [2:0]            in_op_i,
    input  logic [1:0]            in_eew_i,
    input  logic [31:0]           in_init_i,
    input  logic [LANES*32-1:0]   in_data_i,
    input  logic [LANES-1:0]      in_en_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [31:0]           out_result_o,
    output logic [CNT_W-1:0]      out_count_o
);

    localparam int unsigned PW = $clog2(LANES + 1);

    typedef enum logic {ST_ACC, ST_OUT} state_e;

    state_e            state_q, state_d;
    logic [31:0]       acc_q, acc_d, res_q, res_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_out_q, cnt_out_d;
    logic [31:0]       node [1:2*LANES-1];
    logic [31:0]       base, folded;
    logic [PW-1:0]     pop;
    logic [CNT_W:0]    csum;
    logic [CNT_W-1:0]  cnt_sat;

    function automatic logic [31:0] emask(input logic [1:0] eew);
        case (eew)
            2'd0:    return 32'h0000_00FF;
            2'd1:    return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] sext(input logic [31:0] v, input logic [1:0] eew);
        case (eew)
            2'd0:    return {{24{v[7]}}, v[7:0]};
            2'd1:    return {{16{v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    // Identity element per op, so disabled lanes leave the fold unchanged.
    function automatic logic [31:0] ident(input logic [2:0] op, input logic [1:0] eew);
        case (op)
            3'd1, 3'd4: return emask(eew);
            3'd5:       return emask(eew) >> 1;
            3'd7:       return emask(eew) & ~(emask(eew) >> 1);
            default:    return '0;
        endcase
    endfunction

    function automatic logic [31:0] op2(input logic [2:0] op, input logic [1:0] eew,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a & b;
            3'd2:    r = a | b;
            3'd3:    r = a ^ b;
            3'd4:    r = (a < b) ? a : b;
            3'd5:    r = ($signed(sext(a, eew)) < $signed(sext(b, eew))) ? a : b;
            3'd6:    r = (a > b) ? a : b;
            default: r = ($signed(sext(a, eew)) > $signed(sext(b, eew))) ? a : b;
        endcase
        return r & emask(eew);
    endfunction

    // Heap-indexed tree: leaves at [LANES, 2*LANES-1], root at node[1].
    for (genvar l = 0; l < LANES; l++) begin : g_leaf
        assign node[LANES+l] = in_en_i[l] ? (in_data_i[l*32 +: 32] & emask(in_eew_i))
                                          : ident(in_op_i, in_eew_i);
    end
    for (genvar i = 1; i < LANES; i++) begin : g_tree
        assign node[i] = op2(in_op_i, in_eew_i, node[2*i], node[2*i+1]);
    end

    always_comb begin
        pop = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            pop = pop + PW'(in_en_i[l]);
        end
    end

    assign base    = in_first_i ? (in_init_i & emask(in_eew_i)) : acc_q;
    assign folded  = op2(in_op_i, in_eew_i, base, node[1]);
    assign csum    = {1'b0, (in_first_i ? '0 : cnt_q)} + (CNT_W+1)'(pop);
    assign cnt_sat = csum[CNT_W] ? '1 : csum[CNT_W-1:0];

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        cnt_out_d   = cnt_out_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            ST_ACC: begin
                in_ready_o = ~flush_i;
                if (in_valid_i && !flush_i) begin
                    acc_d = folded;
                    cnt_d = cnt_sat;
                    if (in_last_i) begin
                        res_d     = folded;
                        cnt_out_d = cnt_sat;
                        state_d   = ST_OUT;
                    end
                end
            end
            default: begin
                out_valid_o = 1'b1;
                if (out_ready_i) state_d = ST_ACC;
            end
        endcase
        if (flush_i) begin
            state_d   = ST_ACC;
            acc_d     = '0;
            cnt_d     = '0;
            res_d     = '0;
            cnt_out_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            state_q   <= ST_ACC;
            acc_q     <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
            cnt_out_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            cnt_out_q <= cnt_out_d;
        end
    end

    assign out_result_o = res_q;
    assign out_count_o  = cnt_out_q;

endmodule

// File: tb/tb_vproc_red_lanes.sv
// Self-checking bench for vproc_red_lanes: directed cases plus randomized instructions
// checked against a scalar sequential-fold reference model.
module tb_vproc_red_lanes;

    localparam int unsigned LANES = 4;
    localparam int unsigned CNT_W = 16;

    logic                 clk, rst_n, flush, in_valid, in_ready, in_first, in_last;
    logic [2:0]           in_op;
    logic [1:0]           in_eew;
    logic [31:0]          in_init;
    logic [LANES*32-1:0]  in_data;
    logic [LANES-1:0]     in_en;
    logic                 out_valid, out_ready;
    logic [31:0]          out_result;
    logic [CNT_W-1:0]     out_count;

    int n_chk = 0;
    int n_bad = 0;

    longint unsigned m_acc;
    int              m_cnt;

    vproc_red_lanes #(.LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .async_rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_first_i(in_first), .in_last_i(in_last),
        .in_op_i(in_op), .in_eew_i(in_eew), .in_init_i(in_init),
        .in_data_i(in_data), .in_en_i(in_en),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_result_o(out_result), .out_count_o(out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: fold active elements one at a time using plain integer arithmetic.
    function automatic longint unsigned ref_op(int op, int w, longint unsigned a, longint unsigned b);
        longint unsigned md = 64'd1 << w;
        longint sa = (a >= md / 2) ? longint'(a) - longint'(md) : longint'(a);
        longint sb = (b >= md / 2) ? longint'(b) - longint'(md) : longint'(b);
        case (op)
            0: return (a + b) % md;
            1: return a & b;
            2: return a | b;
            3: return a ^ b;
            4: return (a < b) ? a : b;
            5: return (sa < sb) ? a : b;
            6: return (a > b) ? a : b;
            default: return (sa > sb) ? a : b;
        endcase
    endfunction

    task automatic send_beat(input bit first, input bit last, input logic [2:0] op,
                             input logic [1:0] eew, input logic [31:0] init,
                             input logic [LANES*32-1:0] data, input logic [LANES-1:0] en);
        int t = 0;
        int w = 8 << eew;
        longint unsigned md = 64'd1 << w;
        logic [31:0] elem;
        @(negedge clk);
        in_valid = 1'b1; in_first = first; in_last = last; in_op = op;
        in_eew = eew; in_init = init; in_data = data; in_en = en;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("beat_ready_timeout", 0, 1);
        end else begin
            if (first) begin
                m_acc = longint'(init) % md;
                m_cnt = 0;
            end
            for (int l = 0; l < LANES; l++) begin
                if (en[l]) begin
                    elem  = data[l*32 +: 32];
                    m_acc = ref_op(op, w, m_acc, longint'(elem) % md);
                    m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic get_result(input bit use_exp, input logic [31:0] er, input logic [15:0] ec,
                              input int hold);
        int t = 0;
        chk("latency", out_valid, 1);
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("result", out_result, m_acc[31:0]);
        chk("count", out_count, 64'(m_cnt));
        if (use_exp) begin
            chk("result_dir", out_result, er);
            chk("count_dir", out_count, ec);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_result", out_result, m_acc[31:0]);
            chk("hold_inready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("drain_valid", out_valid, 0);
        chk("drain_inready", in_ready, 1);
    endtask

    initial begin
        logic [LANES*32-1:0] d;
        int nb;
        logic [2:0] op;
        logic [1:0] eew;
        logic [31:0] init;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        in_op = '0; in_eew = '0; in_init = '0; in_data = '0; in_en = '0; out_ready = 1'b0;
        m_acc = 0; m_cnt = 0;
        #22;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_result", out_result, 0);
        chk("rst_count", out_count, 0);
        chk("rst_inready", in_ready, 1);

        // SUM eew32, single beat
        send_beat(1, 1, 3'd0, 2'd2, 32'd10, {32'd4, 32'd3, 32'd2, 32'd1}, 4'b1111);
        get_result(1, 32'd20, 16'd4, 0);

        // MIN eew8, signed, upper data bits ignored
        send_beat(1, 0, 3'd5, 2'd0, 32'h05, {32'h11, 32'h22, 32'h7F, 32'hABCD_EF80}, 4'b0001);
        send_beat(0, 1, 3'd5, 2'd0, 32'h05, {32'h11, 32'h11, 32'h11, 32'hF0}, 4'b0000);
        get_result(1, 32'h80, 16'd1, 0);

        // MAXU eew16, nothing active
        send_beat(1, 0, 3'd6, 2'd1, 32'h1234_ABCD, {4{32'hFFFF_FFFF}}, 4'b0000);
        send_beat(0, 1, 3'd6, 2'd1, 32'h1234_ABCD, {4{32'hFFFF_FFFF}}, 4'b0000);
        get_result(1, 32'h0000_ABCD, 16'd0, 0);

        // SUM eew8 wrap
        send_beat(1, 1, 3'd0, 2'd0, 32'hFF, {32'd0, 32'd0, 32'd0, 32'd1}, 4'b0001);
        get_result(1, 32'h0, 16'd1, 0);

        // Backpressure hold
        send_beat(1, 1, 3'd0, 2'd2, 32'd10, {32'd4, 32'd3, 32'd2, 32'd1}, 4'b1111);
        get_result(1, 32'd20, 16'd4, 5);

        // Flush mid-instruction; beat presented during flush is dropped
        send_beat(1, 0, 3'd0, 2'd2, 32'd100, {4{32'd1000}}, 4'b1111);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
        #1;
        chk("flush_inready", in_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_novalid", out_valid, 0);
        send_beat(1, 0, 3'd0, 2'd2, 32'd7, {32'd0, 32'd0, 32'd2, 32'd1}, 4'b0011);
        send_beat(0, 1, 3'd0, 2'd2, 32'd7, {32'd9, 32'd9, 32'd9, 32'd5}, 4'b0001);
        get_result(1, 32'd15, 16'd3, 0);

        // Flush while a result is pending
        send_beat(1, 1, 3'd1, 2'd2, 32'hFFFF_FFFF, {4{32'h0F0F_0F0F}}, 4'b1010);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_out_count", out_count, 0);

        // Asynchronous reset while a result is pending
        send_beat(1, 1, 3'd2, 2'd1, 32'h1, {4{32'h00F0}}, 4'b1111);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_result", out_result, 0);
        chk("arst_count", out_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized instructions, occasional mid-instruction restart
        for (int k = 0; k < 60; k++) begin
            op   = 3'($urandom_range(0, 7));
            eew  = 2'($urandom_range(0, 2));
            init = $urandom;
            nb   = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                for (int l = 0; l < LANES; l++) d[l*32 +: 32] = $urandom;
                send_beat((b == 0) || ($urandom_range(0, 7) == 0), b == nb - 1, op, eew, init, d,
                          4'($urandom_range(0, 15)));
            end
            get_result(0, '0, '0, $urandom_range(0, 3));
        end

        // Active-element counter saturation
        for (int b = 0; b <= 16384; b++) begin
            send_beat(b == 0, b == 16384, 3'd0, 2'd0, 32'h3, {32'h4, 32'h3, 32'h2, 32'h1}, 4'b1111);
        end
        chk("count_sat", out_count, 16'hFFFF);
        get_result(0, '0, '0, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
